// File: rtl/scpad_types_pkg.sv
// ---------------------------------------------------------------------------
// scpad_types_pkg
//   Shared scratchpad types.
//   - slot_mask / enable_mask / scpad_data : SRAM row select, bank enables
//     and data word.
//   - arb_id_t       : requester identity used by the SRAM arbiter.
//   - sram_arb_req_t : one request as seen by the SRAM issue stage.
//   - starve_cnt_t   : width of the per-requester starvation counters.
//   - starve_next()  : next value of a starvation counter.
// ---------------------------------------------------------------------------
package scpad_types_pkg;

  localparam int SLOT_W   = 8;
  localparam int EN_W     = 4;
  localparam int DATA_W   = 32;
  localparam int STARVE_W = 8;

  typedef logic [SLOT_W-1:0]   slot_mask;
  typedef logic [EN_W-1:0]     enable_mask;
  typedef logic [DATA_W-1:0]   scpad_data;
  typedef logic [STARVE_W-1:0] starve_cnt_t;

  typedef enum logic [1:0] {
    ARB_BE = 2'd0,
    ARB_VC = 2'd1,
    ARB_SA = 2'd2
  } arb_id_t;

  typedef struct packed {
    logic       write;
    slot_mask   slot;
    enable_mask en;
    scpad_data  wdata;
  } sram_arb_req_t;

  // Starvation counter update. A busy SRAM freezes the counter because
  // nobody could have been served; otherwise an idle or served requester
  // starts over and a waiting one counts up until it reaches the limit.
  function automatic starve_cnt_t starve_next(
    input starve_cnt_t cnt,
    input starve_cnt_t lim,
    input logic        valid,
    input logic        xfer,
    input logic        busy
  );
    starve_cnt_t nxt;
    if (busy) begin
      nxt = cnt;
    end else if (!valid || xfer) begin
      nxt = '0;
    end else if (cnt >= lim) begin
      nxt = lim;
    end else begin
      nxt = cnt + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/scpad_sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// scpad_sram_arbiter_if
//   Bundles the three requester ports (BE, VC, SA), the shared response
//   bus, the SRAM control port and two starvation-counter debug taps.
//   Modports:
//     slave  : arbiter view (requests/sram_busy/sram_rdata in, the rest out)
//     master : environment view (requesters plus SRAM control)
//
//   Handshake: a request transfers in any cycle where *_req_valid and
//   *_req_ready are both 1. While valid is high and ready is low the
//   requester keeps write/slot/en/wdata stable; it may drop valid without
//   a transfer. Ready never depends on a registered ack, only on the valids,
//   sram_busy and the starvation counters of the current cycle. A read
//   answers with exactly one *_res_valid pulse carrying res_rdata; a write
//   is complete at transfer and never answers.
// ---------------------------------------------------------------------------
interface scpad_sram_arbiter_if;
  import scpad_types_pkg::*;

  logic        be_req_valid, vc_req_valid, sa_req_valid;
  logic        be_req_write, vc_req_write, sa_req_write;
  slot_mask    be_req_slot,  vc_req_slot,  sa_req_slot;
  enable_mask  be_req_en,    vc_req_en,    sa_req_en;
  scpad_data   be_req_wdata, vc_req_wdata, sa_req_wdata;
  logic        be_req_ready, vc_req_ready, sa_req_ready;

  logic        be_res_valid, vc_res_valid, sa_res_valid;
  scpad_data   res_rdata;

  logic        sram_busy;
  logic        sram_valid;
  logic        sram_write;
  slot_mask    sram_slot;
  enable_mask  sram_en;
  scpad_data   sram_wdata;
  scpad_data   sram_rdata;

  starve_cnt_t dbg_vc_starve;
  starve_cnt_t dbg_sa_starve;

  modport slave (
    input  be_req_valid, vc_req_valid, sa_req_valid,
    input  be_req_write, vc_req_write, sa_req_write,
    input  be_req_slot,  vc_req_slot,  sa_req_slot,
    input  be_req_en,    vc_req_en,    sa_req_en,
    input  be_req_wdata, vc_req_wdata, sa_req_wdata,
    output be_req_ready, vc_req_ready, sa_req_ready,
    output be_res_valid, vc_res_valid, sa_res_valid,
    output res_rdata,
    input  sram_busy,
    output sram_valid, sram_write, sram_slot, sram_en, sram_wdata,
    input  sram_rdata,
    output dbg_vc_starve, dbg_sa_starve
  );

  modport master (
    output be_req_valid, vc_req_valid, sa_req_valid,
    output be_req_write, vc_req_write, sa_req_write,
    output be_req_slot,  vc_req_slot,  sa_req_slot,
    output be_req_en,    vc_req_en,    sa_req_en,
    output be_req_wdata, vc_req_wdata, sa_req_wdata,
    input  be_req_ready, vc_req_ready, sa_req_ready,
    input  be_res_valid, vc_res_valid, sa_res_valid,
    input  res_rdata,
    output sram_busy,
    input  sram_valid, sram_write, sram_slot, sram_en, sram_wdata,
    output sram_rdata,
    input  dbg_vc_starve, dbg_sa_starve
  );

endinterface

// File: rtl/scpad_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// scpad_rd_tag_pipe
//   Fixed-latency shift pipe that carries a {valid, tag} pair alongside an
//   SRAM read so the answer can be routed back to its requester.
//   Parameters: DEPTH (cycles from in_* to out_*), TAG_W (tag width).
//   Ports:
//     CLK, nRST     : clock, synchronous active-low reset (clears all stages)
//     in_valid_i    : a read is being issued this cycle
//     in_tag_i      : who issued it
//     out_valid_o   : read data for out_tag_o is on the SRAM bus now
//     out_tag_o     : requester owning that data
// ---------------------------------------------------------------------------
module scpad_rd_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic [DEPTH-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid_i;
      // Tags of empty slots are held at zero so idle stages look clean.
      tag_q[0] <= in_valid_i ? in_tag_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/scpad_sram_arbiter.sv
// ---------------------------------------------------------------------------
// scpad_sram_arbiter
//   Three-way arbiter (BE, VC, SA) in front of a single scratchpad SRAM.
//   One request is accepted per cycle, registered into an issue stage that
//   drives the SRAM on the following cycle, and reads are answered on a
//   shared response bus RD_LAT cycles after issue.
//   Parameters:
//     RD_LAT     : SRAM read latency, issue to sram_rdata (1..8)
//     STARVE_MAX : lost arbitrations before VC/SA is promoted (1..255)
//   Ports:
//     CLK  : clock
//     nRST : synchronous active-low reset
//     bus  : requester, response and SRAM signals (slave modport)
// ---------------------------------------------------------------------------
module scpad_sram_arbiter
  import scpad_types_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  scpad_sram_arbiter_if.slave  bus
);

  localparam starve_cnt_t STARVE_LIM = starve_cnt_t'(STARVE_MAX);

  // -------------------------------------------------------------------------
  // Request views
  // -------------------------------------------------------------------------
  sram_arb_req_t be_req, vc_req, sa_req;

  assign be_req = {bus.be_req_write, bus.be_req_slot, bus.be_req_en, bus.be_req_wdata};
  assign vc_req = {bus.vc_req_write, bus.vc_req_slot, bus.vc_req_en, bus.vc_req_wdata};
  assign sa_req = {bus.sa_req_write, bus.sa_req_slot, bus.sa_req_en, bus.sa_req_wdata};

  // -------------------------------------------------------------------------
  // Arbitration
  //   Order: SA promoted, VC promoted, BE, VC, SA. BE has no counter, so a
  //   continuously busy BE is only interrupted through promotion. Nothing
  //   is granted while the SRAM is busy or the block is in reset.
  // -------------------------------------------------------------------------
  starve_cnt_t vc_starve_q, vc_starve_d;
  starve_cnt_t sa_starve_q, sa_starve_d;
  logic        vc_promo, sa_promo;
  logic        be_gnt, vc_gnt, sa_gnt, any_gnt;

  always_comb begin
    be_gnt   = 1'b0;
    vc_gnt   = 1'b0;
    sa_gnt   = 1'b0;
    vc_promo = bus.vc_req_valid && (vc_starve_q == STARVE_LIM);
    sa_promo = bus.sa_req_valid && (sa_starve_q == STARVE_LIM);
    if (nRST && !bus.sram_busy) begin
      if (sa_promo) begin
        sa_gnt = 1'b1;
      end else if (vc_promo) begin
        vc_gnt = 1'b1;
      end else if (bus.be_req_valid) begin
        be_gnt = 1'b1;
      end else if (bus.vc_req_valid) begin
        vc_gnt = 1'b1;
      end else if (bus.sa_req_valid) begin
        sa_gnt = 1'b1;
      end
    end
  end

  assign any_gnt          = be_gnt || vc_gnt || sa_gnt;
  assign bus.be_req_ready = be_gnt;
  assign bus.vc_req_ready = vc_gnt;
  assign bus.sa_req_ready = sa_gnt;

  assign vc_starve_d = starve_next(vc_starve_q, STARVE_LIM, bus.vc_req_valid,
                                   vc_gnt, bus.sram_busy);
  assign sa_starve_d = starve_next(sa_starve_q, STARVE_LIM, bus.sa_req_valid,
                                   sa_gnt, bus.sram_busy);

  // -------------------------------------------------------------------------
  // Winner select
  // -------------------------------------------------------------------------
  sram_arb_req_t sel_req;
  arb_id_t       sel_id;

  always_comb begin
    sel_req = '0;
    sel_id  = ARB_BE;
    if (sa_gnt) begin
      sel_req = sa_req;
      sel_id  = ARB_SA;
    end else if (vc_gnt) begin
      sel_req = vc_req;
      sel_id  = ARB_VC;
    end else if (be_gnt) begin
      sel_req = be_req;
      sel_id  = ARB_BE;
    end
  end

  // -------------------------------------------------------------------------
  // Issue stage
  //   Fields are zeroed on idle cycles so the SRAM bus is quiet whenever
  //   sram_valid is low.
  // -------------------------------------------------------------------------
  logic          iss_valid_q, iss_valid_d;
  sram_arb_req_t iss_req_q,   iss_req_d;
  arb_id_t       iss_id_q,    iss_id_d;

  assign iss_valid_d = any_gnt;
  assign iss_req_d   = any_gnt ? sel_req : '0;
  assign iss_id_d    = any_gnt ? sel_id  : ARB_BE;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      iss_valid_q <= 1'b0;
      iss_req_q   <= '0;
      iss_id_q    <= ARB_BE;
      vc_starve_q <= '0;
      sa_starve_q <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_req_q   <= iss_req_d;
      iss_id_q    <= iss_id_d;
      vc_starve_q <= vc_starve_d;
      sa_starve_q <= sa_starve_d;
    end
  end

  assign bus.sram_valid    = iss_valid_q;
  assign bus.sram_write    = iss_req_q.write;
  assign bus.sram_slot     = iss_req_q.slot;
  assign bus.sram_en       = iss_req_q.en;
  assign bus.sram_wdata    = iss_req_q.wdata;
  assign bus.dbg_vc_starve = vc_starve_q;
  assign bus.dbg_sa_starve = sa_starve_q;

  // -------------------------------------------------------------------------
  // Read return
  //   The tag enters the pipe in the issue cycle, independent of sram_busy,
  //   so it lines up with sram_rdata exactly RD_LAT cycles later.
  // -------------------------------------------------------------------------
  logic       rsp_valid;
  logic [1:0] rsp_tag;
  logic       rsp_live;
  arb_id_t    rsp_id;

  scpad_rd_tag_pipe #(
    .DEPTH (RD_LAT),
    .TAG_W (2)
  ) u_rd_tag_pipe (
    .CLK         (CLK),
    .nRST        (nRST),
    .in_valid_i  (iss_valid_q && !iss_req_q.write),
    .in_tag_i    (iss_id_q),
    .out_valid_o (rsp_valid),
    .out_tag_o   (rsp_tag)
  );

  assign rsp_id   = arb_id_t'(rsp_tag);
  // Responses are suppressed while reset is asserted so no stale read can
  // surface in the reset cycle itself.
  assign rsp_live = rsp_valid && nRST;

  assign bus.be_res_valid = rsp_live && (rsp_id == ARB_BE);
  assign bus.vc_res_valid = rsp_live && (rsp_id == ARB_VC);
  assign bus.sa_res_valid = rsp_live && (rsp_id == ARB_SA);
  assign bus.res_rdata    = rsp_live ? bus.sram_rdata : '0;

endmodule

// File: tb/tb_scpad_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scpad_sram_arbiter
//   Directed scenarios for reset, single read, starvation promotion,
//   back-to-back reads, busy stalls, writes and reset during a read, then a
//   randomized run checked against a cycle-level reference model.
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_scpad_sram_arbiter;
  import scpad_types_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;
  localparam int N_RAND     = 400;
  localparam int REC_W      = 1 + SLOT_W + EN_W + DATA_W;

  // ----------------------------------------------------------------- clock/reset
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  scpad_sram_arbiter_if bus_if ();

  scpad_sram_arbiter #(
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus_if.slave)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "time limit");
  end

  // ----------------------------------------------------------------- drivers
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input int r, input bit v, input bit w, input slot_mask s,
                           input enable_mask e, input scpad_data d);
    case (r)
      0: begin
        bus_if.be_req_valid = v; bus_if.be_req_write = w; bus_if.be_req_slot = s;
        bus_if.be_req_en = e; bus_if.be_req_wdata = d;
      end
      1: begin
        bus_if.vc_req_valid = v; bus_if.vc_req_write = w; bus_if.vc_req_slot = s;
        bus_if.vc_req_en = e; bus_if.vc_req_wdata = d;
      end
      default: begin
        bus_if.sa_req_valid = v; bus_if.sa_req_write = w; bus_if.sa_req_slot = s;
        bus_if.sa_req_en = e; bus_if.sa_req_wdata = d;
      end
    endcase
  endtask

  task automatic idle_inputs();
    for (int r = 0; r < 3; r++) drive_req(r, 1'b0, 1'b0, '0, '0, '0);
    bus_if.sram_busy  = 1'b0;
    bus_if.sram_rdata = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    step();
    step();
    nRST = 1'b1;
  endtask

  function automatic logic [2:0] ready_vec();
    return {bus_if.be_req_ready, bus_if.vc_req_ready, bus_if.sa_req_ready};
  endfunction

  function automatic logic [2:0] res_vec();
    return {bus_if.be_res_valid, bus_if.vc_res_valid, bus_if.sa_res_valid};
  endfunction

  function automatic logic [REC_W-1:0] sram_rec();
    return {bus_if.sram_write, bus_if.sram_slot, bus_if.sram_en, bus_if.sram_wdata};
  endfunction

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    nRST = 1'b0;
    for (int r = 0; r < 3; r++) drive_req(r, 1'b1, 1'b0, 8'h01, 4'h1, 32'h0);
    bus_if.sram_rdata = 32'hDEADBEEF;
    step();
    step();
    @(negedge CLK);
    n_checks++;
    if (ready_vec() !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 000", ready_vec());
    end
    n_checks++;
    if (bus_if.sram_valid !== 1'b0 || sram_rec() !== '0) begin
      n_fail++; $display("FAIL reset_sram: got valid=%b rec=%h expected 0/0", bus_if.sram_valid, sram_rec());
    end
    n_checks++;
    if (res_vec() !== 3'b000 || bus_if.res_rdata !== '0) begin
      n_fail++; $display("FAIL reset_res: got %b data=%h expected 000/0", res_vec(), bus_if.res_rdata);
    end
    n_checks++;
    if (bus_if.dbg_vc_starve !== 8'd0 || bus_if.dbg_sa_starve !== 8'd0) begin
      n_fail++; $display("FAIL reset_starve: got vc=%0d sa=%0d expected 0/0", bus_if.dbg_vc_starve, bus_if.dbg_sa_starve);
    end
    step();
    nRST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ready_vec() !== 3'b100) begin
      n_fail++; $display("FAIL reset_first_accept: got %b expected 100", ready_vec());
    end
    step();
    idle_inputs();
    @(negedge CLK);
    n_checks++;
    if (bus_if.sram_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_issue: got sram_valid=%b expected 1", bus_if.sram_valid);
    end
  endtask

  task automatic test_be_read();
    do_reset();
    drive_req(0, 1'b1, 1'b0, 8'h03, 4'hF, 32'h0);
    @(negedge CLK);
    n_checks++;
    if (ready_vec() !== 3'b100) begin
      n_fail++; $display("FAIL be_read_ready: got %b expected 100", ready_vec());
    end
    step();
    idle_inputs();
    @(negedge CLK);
    n_checks++;
    if (bus_if.sram_valid !== 1'b1 || sram_rec() !== {1'b0, 8'h03, 4'hF, 32'h0}) begin
      n_fail++; $display("FAIL be_read_issue: got valid=%b rec=%h expected 1/%h", bus_if.sram_valid, sram_rec(), {1'b0, 8'h03, 4'hF, 32'h0});
    end
    step();
    @(negedge CLK);
    n_checks++;
    if (res_vec() !== 3'b000 || bus_if.sram_valid !== 1'b0) begin
      n_fail++; $display("FAIL be_read_early: got res=%b sram_valid=%b expected 000/0", res_vec(), bus_if.sram_valid);
    end
    step();
    bus_if.sram_rdata = 32'h12345678;
    @(negedge CLK);
    n_checks++;
    if (res_vec() !== 3'b100 || bus_if.res_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL be_read_resp: got res=%b data=%h expected 100/12345678", res_vec(), bus_if.res_rdata);
    end
    step();
    @(negedge CLK);
    n_checks++;
    if (res_vec() !== 3'b000 || bus_if.res_rdata !== '0) begin
      n_fail++; $display("FAIL be_read_after: got res=%b data=%h expected 000/0", res_vec(), bus_if.res_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [2:0] exp_rdy;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      for (int r = 0; r < 3; r++) drive_req(r, 1'b1, 1'b0, 8'(r), 4'h1, 32'h0);
      @(negedge CLK);
      exp_rdy = (k == 8) ? 3'b001 : (k == 9) ? 3'b010 : 3'b100;
      n_checks++;
      if (ready_vec() !== exp_rdy) begin
        n_fail++; $display("FAIL starve_grant k=%0d: got %b expected %b", k, ready_vec(), exp_rdy);
      end
      if (k >= 1) begin
        n_checks++;
        if (bus_if.sram_valid !== 1'b1) begin
          n_fail++; $display("FAIL starve_issue k=%0d: got sram_valid=%b expected 1", k, bus_if.sram_valid);
        end
      end
      if (k == 9) begin
        n_checks++;
        if (bus_if.dbg_sa_starve !== 8'd0 || bus_if.dbg_vc_starve !== 8'd8) begin
          n_fail++; $display("FAIL starve_sa_clear: got sa=%0d vc=%0d expected 0/8", bus_if.dbg_sa_starve, bus_if.dbg_vc_starve);
        end
      end
      if (k == 10) begin
        n_checks++;
        if (bus_if.dbg_vc_starve !== 8'd0 || bus_if.dbg_sa_starve !== 8'd1) begin
          n_fail++; $display("FAIL starve_vc_clear: got vc=%0d sa=%0d expected 0/1", bus_if.dbg_vc_starve, bus_if.dbg_sa_starve);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_rdy, exp_res;
    scpad_data  exp_data;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      idle_inputs();
      if (k == 0) drive_req(1, 1'b1, 1'b0, 8'h10, 4'h2, 32'h0);
      if (k == 1) drive_req(2, 1'b1, 1'b0, 8'h20, 4'h4, 32'h0);
      if (k == 2) drive_req(0, 1'b1, 1'b0, 8'h30, 4'h8, 32'h0);
      bus_if.sram_rdata = (k == 3) ? 32'hA : (k == 4) ? 32'hB : (k == 5) ? 32'hC : 32'h55;
      @(negedge CLK);
      exp_rdy  = (k == 0) ? 3'b010 : (k == 1) ? 3'b001 : (k == 2) ? 3'b100 : 3'b000;
      exp_res  = (k == 3) ? 3'b010 : (k == 4) ? 3'b001 : (k == 5) ? 3'b100 : 3'b000;
      exp_data = (k >= 3 && k <= 5) ? bus_if.sram_rdata : 32'h0;
      n_checks++;
      if (ready_vec() !== exp_rdy) begin
        n_fail++; $display("FAIL b2b_ready k=%0d: got %b expected %b", k, ready_vec(), exp_rdy);
      end
      n_checks++;
      if (bus_if.sram_valid !== (k >= 1 && k <= 3)) begin
        n_fail++; $display("FAIL b2b_issue k=%0d: got sram_valid=%b expected %b", k, bus_if.sram_valid, (k >= 1 && k <= 3));
      end
      n_checks++;
      if (res_vec() !== exp_res || bus_if.res_rdata !== exp_data) begin
        n_fail++; $display("FAIL b2b_resp k=%0d: got %b/%h expected %b/%h", k, res_vec(), bus_if.res_rdata, exp_res, exp_data);
      end
      step();
    end
  endtask

  task automatic test_busy();
    do_reset();
    // BE and VC both pending: VC loses three times.
    for (int k = 0; k < 3; k++) begin
      drive_req(0, 1'b1, 1'b0, 8'h01, 4'h1, 32'h0);
      drive_req(1, 1'b1, 1'b0, 8'h02, 4'h1, 32'h0);
      step();
    end
    // SRAM busy: nobody accepted, VC counter frozen at 3.
    for (int k = 0; k < 5; k++) begin
      bus_if.sram_busy = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (ready_vec() !== 3'b000 || bus_if.dbg_vc_starve !== 8'd3) begin
        n_fail++; $display("FAIL busy_hold k=%0d: got ready=%b vc=%0d expected 000/3", k, ready_vec(), bus_if.dbg_vc_starve);
      end
      step();
    end
    // Busy gone: counter resumes from 3, so VC is promoted on the sixth cycle.
    for (int k = 0; k < 6; k++) begin
      bus_if.sram_busy = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (ready_vec() !== ((k < 5) ? 3'b100 : 3'b010) || bus_if.dbg_vc_starve !== 8'(3 + k)) begin
        n_fail++; $display("FAIL busy_resume k=%0d: got ready=%b vc=%0d expected %b/%0d", k, ready_vec(), bus_if.dbg_vc_starve, (k < 5) ? 3'b100 : 3'b010, 3 + k);
      end
      step();
    end
    // VC alone behind a busy SRAM, granted the cycle busy drops.
    drive_req(0, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      bus_if.sram_busy = (k < 5);
      @(negedge CLK);
      n_checks++;
      if (ready_vec() !== ((k < 5) ? 3'b000 : 3'b010) || bus_if.dbg_vc_starve !== 8'd0) begin
        n_fail++; $display("FAIL busy_vc_only k=%0d: got ready=%b vc=%0d expected %b/0", k, ready_vec(), bus_if.dbg_vc_starve, (k < 5) ? 3'b000 : 3'b010);
      end
      step();
    end
  endtask

  task automatic test_write();
    do_reset();
    drive_req(2, 1'b1, 1'b1, 8'h05, 4'h3, 32'hCAFEF00D);
    @(negedge CLK);
    n_checks++;
    if (ready_vec() !== 3'b001) begin
      n_fail++; $display("FAIL write_ready: got %b expected 001", ready_vec());
    end
    step();
    idle_inputs();
    @(negedge CLK);
    n_checks++;
    if (bus_if.sram_valid !== 1'b1 || sram_rec() !== {1'b1, 8'h05, 4'h3, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL write_issue: got valid=%b rec=%h expected 1/%h", bus_if.sram_valid, sram_rec(), {1'b1, 8'h05, 4'h3, 32'hCAFEF00D});
    end
    for (int k = 0; k < 6; k++) begin
      step();
      bus_if.sram_rdata = $urandom | 32'h1;
      @(negedge CLK);
      n_checks++;
      if (res_vec() !== 3'b000 || bus_if.res_rdata !== '0) begin
        n_fail++; $display("FAIL write_no_resp k=%0d: got %b/%h expected 000/0", k, res_vec(), bus_if.res_rdata);
      end
    end
    step();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    drive_req(0, 1'b1, 1'b0, 8'h11, 4'hF, 32'h0);
    @(negedge CLK);
    n_checks++;
    if (ready_vec() !== 3'b100) begin
      n_fail++; $display("FAIL inflight_ready: got %b expected 100", ready_vec());
    end
    step();
    idle_inputs();
    step();
    nRST = 1'b0;
    drive_req(0, 1'b1, 1'b0, 8'h12, 4'hF, 32'h0);
    @(negedge CLK);
    n_checks++;
    if (ready_vec() !== 3'b000) begin
      n_fail++; $display("FAIL inflight_rst_ready: got %b expected 000", ready_vec());
    end
    step();
    nRST = 1'b1;
    idle_inputs();
    bus_if.sram_rdata = 32'hFEEDFACE;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      n_checks++;
      if (res_vec() !== 3'b000 || bus_if.res_rdata !== '0 || bus_if.sram_valid !== 1'b0 || sram_rec() !== '0) begin
        n_fail++; $display("FAIL inflight_dropped k=%0d: got res=%b data=%h sram_valid=%b expected all 0", k, res_vec(), bus_if.res_rdata, bus_if.sram_valid);
      end
      step();
    end
  endtask

  // Reference model: per-cycle winner from the priority rules, counters as
  // plain integers, an expected-issue queue and a response schedule indexed
  // by cycle number.
  task automatic test_random();
    bit                pv [3];
    bit                pw [3];
    slot_mask          ps [3];
    enable_mask        pe [3];
    scpad_data         pd [3];
    int                exp_rsp [N_RAND + 16];
    logic [REC_W-1:0]  exp_q [$];
    logic [REC_W-1:0]  exp_rec;
    bit                exp_sv, busy;
    int                vc_cnt, sa_cnt, w;
    logic [2:0]        exp_rdy, exp_res;
    scpad_data         rd, exp_data;

    do_reset();
    foreach (exp_rsp[i]) exp_rsp[i] = -1;
    for (int r = 0; r < 3; r++) pv[r] = 1'b0;
    vc_cnt = 0;
    sa_cnt = 0;

    for (int c = 0; c < N_RAND; c++) begin
      busy = ($urandom_range(0, 7) == 0);
      for (int r = 0; r < 3; r++) begin
        if (pv[r] && !busy && $urandom_range(0, 15) == 0) begin
          pv[r] = 1'b0;
        end else if (!pv[r] && $urandom_range(0, 3) != 0) begin
          pv[r] = 1'b1;
          pw[r] = 1'($urandom_range(0, 1));
          ps[r] = slot_mask'($urandom_range(0, 255));
          pe[r] = enable_mask'($urandom_range(0, 15));
          pd[r] = $urandom;
        end
        drive_req(r, pv[r], pv[r] ? pw[r] : 1'b0, pv[r] ? ps[r] : '0,
                  pv[r] ? pe[r] : '0, pv[r] ? pd[r] : '0);
      end
      rd = $urandom;
      bus_if.sram_busy  = busy;
      bus_if.sram_rdata = rd;
      @(negedge CLK);

      w = -1;
      if (!busy) begin
        if (pv[2] && sa_cnt == STARVE_MAX)      w = 2;
        else if (pv[1] && vc_cnt == STARVE_MAX) w = 1;
        else if (pv[0])                         w = 0;
        else if (pv[1])                         w = 1;
        else if (pv[2])                         w = 2;
      end
      exp_rdy = (w == 0) ? 3'b100 : (w == 1) ? 3'b010 : (w == 2) ? 3'b001 : 3'b000;

      if (exp_q.size() > 0) begin
        exp_rec = exp_q.pop_front();
        exp_sv  = 1'b1;
      end else begin
        exp_rec = '0;
        exp_sv  = 1'b0;
      end

      exp_res  = (exp_rsp[c] == 0) ? 3'b100 : (exp_rsp[c] == 1) ? 3'b010 :
                 (exp_rsp[c] == 2) ? 3'b001 : 3'b000;
      exp_data = (exp_rsp[c] >= 0) ? rd : 32'h0;

      n_checks++;
      if (ready_vec() !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, ready_vec(), exp_rdy);
      end
      n_checks++;
      if (bus_if.sram_valid !== exp_sv || sram_rec() !== exp_rec) begin
        n_fail++; $display("FAIL rand_issue c=%0d: got %b/%h expected %b/%h", c, bus_if.sram_valid, sram_rec(), exp_sv, exp_rec);
      end
      n_checks++;
      if (res_vec() !== exp_res || bus_if.res_rdata !== exp_data) begin
        n_fail++; $display("FAIL rand_resp c=%0d: got %b/%h expected %b/%h", c, res_vec(), bus_if.res_rdata, exp_res, exp_data);
      end
      n_checks++;
      if (bus_if.dbg_vc_starve !== 8'(vc_cnt) || bus_if.dbg_sa_starve !== 8'(sa_cnt)) begin
        n_fail++; $display("FAIL rand_starve c=%0d: got vc=%0d sa=%0d expected %0d/%0d", c, bus_if.dbg_vc_starve, bus_if.dbg_sa_starve, vc_cnt, sa_cnt);
      end

      if (w >= 0) begin
        exp_q.push_back({pw[w], ps[w], pe[w], pd[w]});
        if (!pw[w]) exp_rsp[c + 1 + RD_LAT] = w;
      end
      if (!busy) begin
        vc_cnt = (!pv[1] || w == 1) ? 0 : (vc_cnt < STARVE_MAX) ? vc_cnt + 1 : STARVE_MAX;
        sa_cnt = (!pv[2] || w == 2) ? 0 : (sa_cnt < STARVE_MAX) ? sa_cnt + 1 : STARVE_MAX;
      end
      if (w >= 0) pv[w] = 1'b0;
      step();
    end
  endtask

  // ----------------------------------------------------------------- sequence
  initial begin
    nRST = 1'b0;
    idle_inputs();
    test_reset();
    test_be_read();
    test_starvation();
    test_back_to_back();
    test_busy();
    test_write();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
